// File: rtl/vga_mem_responder_pkg.sv
// Shared constants and types for the VGA frame-buffer responder.
// Carries the former params.v values plus the colour-bar palette.
package vga_mem_responder_pkg;

    localparam int LOG_MEM    = 36;
    localparam int LOG_ADDR   = 19;
    localparam int LOG_HCOUNT = 10;
    localparam int LOG_VCOUNT = 10;

    localparam int FB_WIDTH_WORDS = 320;
    localparam int FB_WIDTH_PIX   = 2 * FB_WIDTH_WORDS;
    localparam int FB_HEIGHT      = 480;
    localparam int ZBT_LATENCY    = 2;

    // Colour bars as {Y, Cr, Cb}, 6 bits each (8-bit studio levels >> 2)
    localparam logic [17:0] BAR_WHITE   = {6'd58, 6'd32, 6'd32};
    localparam logic [17:0] BAR_YELLOW  = {6'd52, 6'd36, 6'd4};
    localparam logic [17:0] BAR_CYAN    = {6'd42, 6'd4,  6'd41};
    localparam logic [17:0] BAR_GREEN   = {6'd36, 6'd8,  6'd13};
    localparam logic [17:0] BAR_MAGENTA = {6'd26, 6'd55, 6'd50};
    localparam logic [17:0] BAR_RED     = {6'd20, 6'd60, 6'd22};
    localparam logic [17:0] BAR_BLUE    = {6'd10, 6'd27, 6'd60};
    localparam logic [17:0] BAR_BLACK   = {6'd4,  6'd32, 6'd32};

    // Where a completing read slot takes its returned word from
    typedef enum logic [1:0] {
        RD_NONE,
        RD_BUS,
        RD_ZERO,
        RD_BAR
    } rd_src_t;

    // One issued memory slot; a synthetic read and a write may share a slot
    typedef struct packed {
        rd_src_t            rd_src;
        logic [2:0]         band;
        logic               wr;
        logic [LOG_MEM-1:0] data;
    } zbt_op_t;

    function automatic logic [17:0] color_bar(input logic [2:0] band);
        logic [17:0] c;
        case (band)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_mem_responder_zbt_op_pipe.sv
// Tag/data shift register tracking issued ZBT slots until their data cycle.
module zbt_op_pipe
    import vga_mem_responder_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  zbt_op_t op_in,
    output zbt_op_t op_out
);

    localparam int unsigned PIPE_DEPTH = ZBT_LATENCY + 1;

    zbt_op_t [PIPE_DEPTH-1:0] stage_q;

    // Shift one slot per cycle; reset discards everything in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[PIPE_DEPTH-2:0], op_in};
        end
    end

    assign op_out = stage_q[PIPE_DEPTH-1];

endmodule

// File: rtl/vga_mem_responder.sv
// VGA-side ZBT responder: serves pixel-pair reads from the display bank and
// fills the back bank from a capture writer in spare slots.
// Optional build macro VGA_TESTPATTERN_EN replaces frame-buffer reads with
// colour bars while keeping the read latency and handshake unchanged.
module vga_mem_responder
    import vga_mem_responder_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_flag,
    input  logic                  vga_flag,
    input  logic [LOG_HCOUNT-1:0] vga_hcount,
    input  logic [LOG_VCOUNT-1:0] vga_vcount,
    output logic [LOG_MEM-1:0]    vga_pixel,
    output logic                  done_vga,
    input  logic                  wr_req,
    input  logic [LOG_ADDR-2:0]   wr_addr,
    input  logic [LOG_MEM-1:0]    wr_data,
    output logic                  wr_ack,
    output logic [LOG_ADDR-1:0]   mem_addr,
    output logic                  mem_we_b,
    output logic [LOG_MEM-1:0]    mem_data_out,
    output logic                  mem_data_oe,
    input  logic [LOG_MEM-1:0]    mem_data_in
);

    logic                disp_bank;
    logic                in_range;
    logic [LOG_ADDR-2:0] vcount_w;
    logic [LOG_ADDR-2:0] rd_word_addr;
    logic                issue_rd;
    logic                issue_wr;
    rd_src_t             rd_src;
    zbt_op_t             op_new;
    zbt_op_t             op_out;

    // Request decode, word address and slot arbitration (reads win)
    always_comb begin
        in_range     = (vga_hcount < LOG_HCOUNT'(FB_WIDTH_PIX)) &&
                       (vga_vcount < LOG_VCOUNT'(FB_HEIGHT));
        vcount_w     = (LOG_ADDR-1)'(vga_vcount);
        rd_word_addr = (vcount_w << 8) + (vcount_w << 6) +
                       (LOG_ADDR-1)'(vga_hcount[LOG_HCOUNT-1:1]);
`ifdef VGA_TESTPATTERN_EN
        issue_rd = 1'b0;
        rd_src   = in_range ? RD_BAR : RD_ZERO;
`else
        issue_rd = vga_flag && in_range;
        rd_src   = in_range ? RD_BUS : RD_ZERO;
`endif
        issue_wr = wr_req && !issue_rd;

        op_new        = '0;
        op_new.rd_src = vga_flag ? rd_src : RD_NONE;
        op_new.band   = vga_hcount[LOG_HCOUNT-1:LOG_HCOUNT-3];
        op_new.wr     = issue_wr;
        op_new.data   = wr_data;
    end

    // Bank swap and the registered ZBT address/control for the issued slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_bank <= 1'b0;
            mem_addr  <= '0;
            mem_we_b  <= 1'b1;
            wr_ack    <= 1'b0;
        end else begin
            if (frame_flag) begin
                disp_bank <= ~disp_bank;
            end
            wr_ack   <= issue_wr;
            mem_we_b <= ~issue_wr;
            if (issue_rd) begin
                mem_addr <= {disp_bank, rd_word_addr};
            end else if (issue_wr) begin
                mem_addr <= {~disp_bank, wr_addr};
            end
        end
    end

    zbt_op_pipe u_op_pipe (
        .clock  (clock),
        .reset  (reset),
        .op_in  (op_new),
        .op_out (op_out)
    );

    // Write data is driven straight from the last stage, i.e. the data cycle
    always_comb begin
        mem_data_oe  = op_out.wr;
        mem_data_out = op_out.wr ? op_out.data : '0;
    end

    // Capture the returned word at the end of the data cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_pixel <= '0;
            done_vga  <= 1'b0;
        end else begin
            done_vga <= (op_out.rd_src != RD_NONE);
            case (op_out.rd_src)
                RD_BUS:  vga_pixel <= mem_data_in;
                RD_ZERO: vga_pixel <= '0;
                RD_BAR:  vga_pixel <= {color_bar(op_out.band), color_bar(op_out.band)};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_responder.sv
// Randomized self-checking bench for vga_mem_responder with a ZBT memory model.
module tb_vga_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_flag = 1'b0;
    logic        vga_flag = 1'b0;
    logic [9:0]  vga_hcount = '0;
    logic [9:0]  vga_vcount = '0;
    logic [35:0] vga_pixel;
    logic        done_vga;
    logic        wr_req = 1'b0;
    logic [17:0] wr_addr = '0;
    logic [35:0] wr_data = '0;
    logic        wr_ack;
    logic [18:0] mem_addr;
    logic        mem_we_b;
    logic [35:0] mem_data_out;
    logic        mem_data_oe;
    logic [35:0] mem_data_in = '0;

    always #5 clock = ~clock;

    vga_mem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .frame_flag   (frame_flag),
        .vga_flag     (vga_flag),
        .vga_hcount   (vga_hcount),
        .vga_vcount   (vga_vcount),
        .vga_pixel    (vga_pixel),
        .done_vga     (done_vga),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .mem_addr     (mem_addr),
        .mem_we_b     (mem_we_b),
        .mem_data_out (mem_data_out),
        .mem_data_oe  (mem_data_oe),
        .mem_data_in  (mem_data_in)
    );

    localparam int NC = 2048;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Per-slot expectations, indexed by the cycle the request was presented
    int          rdreq    [NC];  // 0 none, 1 frame-buffer read, 2 synthetic word
    logic [35:0] rdsyn    [NC];
    logic [18:0] xaddr    [NC];
    bit          swr      [NC];
    logic [35:0] wdat     [NC];
    logic [18:0] obs_addr [NC];
    logic [35:0] exp_pix  [NC];

    logic [18:0] last_addr = '0;
    logic [35:0] last_pix = '0;
    bit          bank = 1'b0;

    logic [35:0] mem [logic [18:0]];

    typedef struct {
        logic [17:0] a;
        logic [35:0] d;
    } wr_t;
    wr_t wq[$];

`ifdef VGA_TESTPATTERN_EN
    int ybar  [8] = '{235, 210, 170, 145, 106,  81,  41,  16};
    int crbar [8] = '{128, 146,  16,  34, 222, 240, 110, 128};
    int cbbar [8] = '{128,  16, 166,  54, 202,  90, 240, 128};

    function automatic logic [17:0] bar(input int b);
        return {6'(ybar[b] >> 2), 6'(crbar[b] >> 2), 6'(cbbar[b] >> 2)};
    endfunction
`endif

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [35:0] memrd(input logic [18:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[16:0], a} ^ 36'h93C5A7E1D;
    endfunction

    task automatic reset_checks(input string tag);
        check_eq({tag, "_pixel"}, vga_pixel, '0);
        check_eq({tag, "_done"}, 36'(done_vga), '0);
        check_eq({tag, "_ack"}, 36'(wr_ack), '0);
        check_eq({tag, "_addr"}, 36'(mem_addr), '0);
        check_eq({tag, "_we_b"}, 36'(mem_we_b), 36'(1));
        check_eq({tag, "_dout"}, mem_data_out, '0);
        check_eq({tag, "_oe"}, 36'(mem_data_oe), '0);
    endtask

    // Checks at a falling edge: address cycle of slot n-1, data cycle of
    // slot n-3, completion of slot n-4; also plays the ZBT read side
    task automatic do_checks();
        int k;
        k = n - 1;
        if (k >= 0) begin
            if (wr_ack && wq.size() > 0) void'(wq.pop_front());
            check_eq("wr_ack", 36'(wr_ack), 36'(swr[k]));
            check_eq("mem_we_b", 36'(mem_we_b), 36'(!swr[k]));
            check_eq("mem_addr", 36'(mem_addr), 36'(last_addr));
            obs_addr[k] = mem_addr;
        end
        k = n - 3;
        mem_data_in = {4'($urandom), $urandom};
        if (k >= 0) begin
            check_eq("mem_data_oe", 36'(mem_data_oe), 36'(swr[k]));
            if (swr[k]) begin
                check_eq("mem_data_out", mem_data_out, wdat[k]);
                mem[xaddr[k]] = wdat[k];
            end
            if (rdreq[k] == 1) begin
                mem_data_in = memrd(obs_addr[k]);
                exp_pix[k]  = memrd(xaddr[k]);
            end else if (rdreq[k] == 2) begin
                exp_pix[k] = rdsyn[k];
            end
        end
        k = n - 4;
        if (k >= 0) begin
            check_eq("done_vga", 36'(done_vga), 36'(rdreq[k] != 0));
            if (rdreq[k] != 0) last_pix = exp_pix[k];
            check_eq("vga_pixel", vga_pixel, last_pix);
        end
    endtask

    // Predict what this cycle's request does, then present it
    task automatic drive(input bit flag, input int h, input int v, input bit frame);
        bit inr;
        bit rd_bus;
        bit wr;
        int a;
        inr = (h < 640) && (v < 480);
        a   = v * 320 + h / 2;
`ifdef VGA_TESTPATTERN_EN
        rd_bus   = 1'b0;
        rdreq[n] = flag ? 2 : 0;
        rdsyn[n] = inr ? {bar(h / 128), bar(h / 128)} : '0;
`else
        rd_bus   = flag && inr;
        rdreq[n] = flag ? (inr ? 1 : 2) : 0;
        rdsyn[n] = '0;
`endif
        wr     = (wq.size() > 0) && !rd_bus;
        swr[n] = wr;
        if (rd_bus) begin
            xaddr[n]  = {bank, 18'(a)};
            last_addr = xaddr[n];
        end else if (wr) begin
            xaddr[n]  = {!bank, wq[0].a};
            wdat[n]   = wq[0].d;
            last_addr = xaddr[n];
        end
        bank ^= frame;

        reset      = 1'b0;
        vga_flag   = flag;
        vga_hcount = 10'(h);
        vga_vcount = 10'(v);
        frame_flag = frame;
        wr_req     = (wq.size() > 0);
        if (wq.size() > 0) begin
            wr_addr = wq[0].a;
            wr_data = wq[0].d;
        end
    endtask

    task automatic cycle(input bit flag, input int h, input int v, input bit frame);
        @(negedge clock);
        n++;
        do_checks();
        drive(flag, h, v, frame);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cycle(1'b0, 0, 0, 1'b0);
    endtask

    // Assert reset for one cycle; everything in flight is forgotten
    task automatic reset_cycle();
        @(negedge clock);
        n++;
        do_checks();
        reset      = 1'b1;
        vga_flag   = 1'b0;
        frame_flag = 1'b0;
        wr_req     = 1'b0;
        #1;
        reset_checks("midrst");
        for (int j = 0; j <= 3; j++) begin
            rdreq[n-j] = 0;
            swr[n-j]   = 1'b0;
        end
        last_addr = '0;
        last_pix  = '0;
        bank      = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset_checks("por");

        // Single read at (5,2) in bank 0
        mem[19'h00282] = 36'hABCDE1234;
        cycle(1'b1, 5, 2, 1'b0);
        idle(4);
`ifndef VGA_TESTPATTERN_EN
        check_eq("t1_pixel", vga_pixel, 36'hABCDE1234);
`endif

        // Read and write presented together; write stalls one slot
        wq.push_back('{a: 18'h10, d: 36'h5A5A});
        cycle(1'b1, 100, 10, 1'b0);
        idle(6);

        // Bank swap coincident with a read, then a read and a write after it
        cycle(1'b1, 0, 0, 1'b1);
        idle(3);
        wq.push_back('{a: 18'h22, d: 36'h123456789});
        cycle(1'b1, 0, 0, 1'b0);
        idle(6);

        // Out-of-range request; pending write takes the slot
        wq.push_back('{a: 18'h33, d: 36'hFEDCBA987});
        cycle(1'b1, 700, 5, 1'b0);
        idle(5);
        cycle(1'b1, 20, 600, 1'b0);
        idle(5);

        // Two consecutive swaps, then a read of what was written
        cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b1, 68, 0, 1'b0);
        idle(5);

        // Back-to-back reads every cycle
        for (int i = 0; i < 8; i++) cycle(1'b1, 639 - i, 479, 1'b0);
        idle(5);

        // Reset one cycle after a read issue
        cycle(1'b1, 8, 8, 1'b0);
        idle(4);
        cycle(1'b1, 9, 9, 1'b0);
        reset_cycle();
        idle(6);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit f;
            bit fr;
            bit local_area;
            int h;
            int v;
            local_area = ($urandom_range(0, 1) == 1);
            if (wq.size() < 4 && $urandom_range(0, 1) == 1) begin
                wq.push_back('{a: local_area ? 18'($urandom_range(0, 63)) : 18'($urandom_range(0, 153599)),
                               d: {4'($urandom), $urandom}});
            end
            f = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end else if (local_area) begin
                h = $urandom_range(0, 127);
                v = 0;
            end else begin
                h = $urandom_range(0, 639);
                v = $urandom_range(0, 479);
            end
            fr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 299) == 0) reset_cycle();
            else cycle(f, h, v, fr);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_mem_responder.md
# vga_mem_responder

Memory-side responder for the VGA display path. It answers the display engine's one-cycle `vga_flag` pixel-pair requests by reading the ZBT frame buffer and returning a 36-bit word (two 18-bit YCrCb pixels) with `done_vga`. It also gives a capture writer access to the back buffer in the free cycles. Display and write banks swap on `frame_flag`, so the displayed frame is never torn.

## Interface
- `LOG_MEM`, 36 (`params.v`): memory word width.
- `LOG_ADDR`, 19 (`params.v`): ZBT word-address width; the MSB is the bank bit.
- `clock` in 1: system clock; the VGA requester's `clock` domain.
- `reset` in 1: asynchronous, active-high reset.
- `frame_flag` in 1: one-cycle pulse at end of frame; swaps the banks.
- `vga_flag` in 1: one-cycle read request.
- `vga_hcount` in 10: pixel column of the request.
- `vga_vcount` in 10: line of the request.
- `vga_pixel` out 36: returned word; `[17:0]` holds the even pixel, `[35:18]` the odd pixel.
- `done_vga` out 1: one-cycle pulse; `vga_pixel` was updated this cycle.
- `wr_req` in 1: writer request; `wr_addr` and `wr_data` are held until `wr_ack`.
- `wr_addr` in 18: back-buffer word address.
- `wr_data` in 36: write data.
- `wr_ack` out 1: one-cycle pulse; the write was accepted.
- `mem_addr` out 19: ZBT address, registered.
- `mem_we_b` out 1: ZBT write enable, active low, registered.
- `mem_data_out` out 36: ZBT write data.
- `mem_data_oe` out 1: drive enable for the ZBT data bus.
- `mem_data_in` in 36: ZBT read data.

## Operation
- **Bank register.** `disp_bank` resets to 0. A `frame_flag` pulse toggles it. Reads use `{disp_bank, a}` and writes use `{~disp_bank, wr_addr}`.
- **Address generation.** `a = vga_vcount*320 + vga_hcount[9:1]`, computed as `(v<<8)+(v<<6)+(h>>1)` in 18 bits. The maximum value is 153599.
- **Out of range.** A request with `vga_hcount >= 640` or `vga_vcount >= 480` issues no ZBT read. It still returns `vga_pixel = 0` with `done_vga` at normal latency.
- **Arbitration each cycle.** The priority order is:
  1. An in-range `vga_flag` issues a read.
  2. Otherwise `wr_req` issues a write and pulses `wr_ack`.
  3. Otherwise the cycle is idle: `mem_we_b = 1`, and `mem_addr` holds its last value.
- **Write stall.** A write that collides with a read is stalled, not dropped, and retries the next cycle.
- **Op pipeline.** A 3-stage shift register carries `{valid, is_read, oob, data}` for every issued slot, following ZBT flow-through-pipelined timing:
  - Read data appears on `mem_data_in` two cycles after the address cycle.
  - Write data must be on the bus two cycles after the address cycle.
- **Write-data drive.** `mem_data_oe` is high only in the write-data cycle. It is never asserted in a read-data cycle.

## Timing
- **Read path.** `vga_flag` is sampled at edge E0. Then:
  - `mem_addr` is valid after E0.
  - The ZBT samples the address at E1.
  - Data is captured into `vga_pixel` at E3.
  - `done_vga` is high for the cycle after E3.
  - Latency is fixed at 3 cycles.
  - `vga_pixel` holds until the next completion.
- **Write path.** `wr_req` is accepted at E0. Then:
  - `wr_ack` is high and `mem_we_b = 0` for the cycle after E0.
  - `mem_data_out = wr_data` with `mem_data_oe = 1` for the cycle after E2.
- **Simultaneous events.**
  - `frame_flag` together with `vga_flag`: the read uses the pre-toggle bank.
  - `frame_flag` together with an accepted write: the write uses the pre-toggle back bank.
  - Two `frame_flag` pulses in consecutive cycles toggle twice.
- **Request rate.** Requests may arrive every cycle; back-to-back reads complete back-to-back. The display engine issues one every 4 cycles, leaving 3 of 4 slots for writes.
- **Reset values.**
  - `vga_pixel = 0`, `done_vga = 0`, `wr_ack = 0`.
  - `mem_addr = 0`, `mem_we_b = 1`, `mem_data_out = 0`, `mem_data_oe = 0`.
  - `disp_bank = 0`.
- **Reset mid-operation.** The pipeline is cleared. No `done_vga` is produced and no write data is driven for slots issued before reset.

## Configuration
- `VGA_TESTPATTERN_EN` defined:
  - Reads issue no ZBT access. The slot is free for writes.
  - The returned word is both pixels set to an 8-band colour-bar YCrCb value selected by `vga_hcount[9:7]`.
  - The same 3-cycle latency and the same `done_vga` behaviour apply.
- `VGA_TESTPATTERN_EN` undefined: normal frame-buffer reads.

## Structure
- **Shared constants in `params.v`.**
  - Existing: `LOG_MEM`, `LOG_ADDR`, `LOG_HCOUNT`, `LOG_VCOUNT`.
  - New: `FB_WIDTH_WORDS` = 320, `FB_HEIGHT` = 480, `ZBT_LATENCY` = 2.
  - New: the colour-bar YCrCb constants.
- **One sub-module, `zbt_op_pipe`.** It is the tag/data shift register of depth `ZBT_LATENCY+1`, with asynchronous clear.

## Test plan
1. **Single read.** Bank 0, `vga_hcount = 5`, `vga_vcount = 2`, `vga_flag` pulse → `mem_addr = 0x00282` one cycle later, `mem_we_b = 1`. Model returns `36'hABCDE1234` → `vga_pixel` equals it, with `done_vga` exactly 3 cycles after the flag.
2. **Read/write collision.** `wr_req` (addr `0x10`, data `0x5A5A`) in the same cycle as `vga_flag` → read issued first. `wr_ack` comes one cycle later, `mem_addr = 0x40010`, `mem_we_b = 0`. Data `0x5A5A` is driven with `mem_data_oe = 1` two cycles after that.
3. **Bank swap.** `frame_flag` with `vga_flag` at (0,0) → read address `0x00000`. The next read at (0,0) → `0x40000`, and writes now target bank 0.
4. **Out of range.** `vga_flag` at `hcount = 700` → no `mem_addr` change, `vga_pixel = 0`, `done_vga` at +3. A pending write takes that slot.
5. **Reset mid-operation.** `reset` asserted 1 cycle after a read issue → no `done_vga`, all outputs at reset values immediately.
6. **Test pattern** (`VGA_TESTPATTERN_EN`). Read at `hcount = 130` → band-1 value in both halves at +3, with no ZBT read.
